// File: rtl/chip8_mem_arbiter_if.sv
// CHIP-8 SRAM arbiter bus bundle.
// Covers loader, CPU and video request ports plus the SRAM side.
interface chip8_mem_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
);
  logic              loading;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              ld_we_n;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;

  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_ack;
  logic [DATA_W-1:0] vid_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport slave (
    input  loading, ld_addr, ld_data, ld_we_n,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  vid_req, vid_addr, mem_rdata,
    output cpu_ack, cpu_rdata, vid_ack, vid_rdata,
    output mem_addr, mem_wdata, mem_we, busy
  );

  modport master (
    output loading, ld_addr, ld_data, ld_we_n,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output vid_req, vid_addr, mem_rdata,
    input  cpu_ack, cpu_rdata, vid_ack, vid_rdata,
    input  mem_addr, mem_wdata, mem_we, busy
  );
endinterface

// File: rtl/chip8_mem_arbiter.sv
// CHIP-8 4 KB SRAM arbiter: loader pass-through while loading,
// otherwise round-robin CPU/video access, one at a time.
module chip8_mem_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
) (
  input logic                clk,
  input logic                reset,
  chip8_mem_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ACC,
    RD,
    DONE
  } state_e;

  typedef enum logic {
    GNT_CPU,
    GNT_VID
  } gnt_e;

  state_e            state_q, state_d;
  gnt_e              last_q, last_d;
  gnt_e              gnt_q, gnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] cpu_rd_q, cpu_rd_d;
  logic [DATA_W-1:0] vid_rd_q, vid_rd_d;
  logic              pick_cpu;
  logic              in_load;

  // CPU wins unless video also asks and CPU had the last turn
  assign pick_cpu = bus.cpu_req &&
                    (!bus.vid_req || last_q == GNT_VID);

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    gnt_d    = gnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = 1'b0;
    cpu_rd_d = cpu_rd_q;
    vid_rd_d = vid_rd_q;
    unique case (state_q)
      IDLE: begin
        if (bus.loading) begin
          state_d = LOAD;
        end else if (bus.cpu_req || bus.vid_req) begin
          if (pick_cpu) begin
            gnt_d   = GNT_CPU;
            addr_d  = bus.cpu_addr;
            wdata_d = bus.cpu_wdata;
            we_d    = bus.cpu_we;
          end else begin
            gnt_d   = GNT_VID;
            addr_d  = bus.vid_addr;
          end
          last_d  = gnt_d;
          state_d = ACC;
        end
      end
      LOAD: begin
        if (!bus.loading) state_d = IDLE;
      end
      ACC: begin
        state_d = we_q ? DONE : RD;
      end
      RD: begin
        if (gnt_q == GNT_CPU) cpu_rd_d = bus.mem_rdata;
        else                  vid_rd_d = bus.mem_rdata;
        state_d = DONE;
      end
      DONE: begin
        state_d = bus.loading ? LOAD : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      last_q   <= GNT_VID;
      gnt_q    <= GNT_CPU;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      cpu_rd_q <= '0;
      vid_rd_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      gnt_q    <= gnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      cpu_rd_q <= cpu_rd_d;
      vid_rd_q <= vid_rd_d;
    end
  end

  // loader owns the SRAM pins combinationally only in LOAD
  assign in_load       = (state_q == LOAD);
  assign bus.mem_addr  = in_load ? bus.ld_addr : addr_q;
  assign bus.mem_wdata = in_load ? bus.ld_data : wdata_q;
  assign bus.mem_we    = in_load ? ~bus.ld_we_n : we_q;

  assign bus.cpu_ack   = (state_q == DONE) && (gnt_q == GNT_CPU);
  assign bus.vid_ack   = (state_q == DONE) && (gnt_q == GNT_VID);
  assign bus.cpu_rdata = cpu_rd_q;
  assign bus.vid_rdata = vid_rd_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_chip8_mem_arbiter.sv
// Bench for chip8_mem_arbiter: SRAM environment, shadow memory
// model and directed plus randomized traffic.
module tb_chip8_mem_arbiter;

  logic clk = 1'b0;
  logic reset;
  logic fill;
  int   npass = 0;
  int   nchk  = 0;

  logic [7:0] sram    [4096];
  logic [7:0] ref_mem [4096];

  always #5 clk = ~clk;

  chip8_mem_arbiter_if bus ();

  chip8_mem_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [7:0] init_byte(input logic [11:0] a);
    return 8'(a * 7 + 3) ^ a[11:4];
  endfunction

  // 1-cycle synchronous-read BRAM
  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < 4096; i++) sram[i] <= init_byte(12'(i));
    end else if (bus.mem_we) begin
      sram[bus.mem_addr] <= bus.mem_wdata;
    end
    bus.mem_rdata <= sram[bus.mem_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h",
                tag, obs, exp);
  endtask

  task automatic wait_ack(input bit vid, input int bound,
                          output int lat);
    lat = -1;
    for (int k = 1; k <= bound; k++) begin
      tick();
      if ((vid ? bus.vid_ack : bus.cpu_ack) === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic cpu_op(input bit we, input logic [11:0] a,
                        input logic [7:0] d, input string tag);
    int lat;
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = a;
    bus.cpu_wdata = d;
    wait_ack(1'b0, 12, lat);
    bus.cpu_req = 1'b0;
    chk({tag, "_lat"}, 32'(lat), we ? 32'd2 : 32'd3);
    if (we) ref_mem[a] = d;
    else chk({tag, "_rd"}, 32'(bus.cpu_rdata), 32'(ref_mem[a]));
    tick();
  endtask

  task automatic vid_op(input logic [11:0] a, input string tag);
    int lat;
    bus.vid_req  = 1'b1;
    bus.vid_addr = a;
    wait_ack(1'b1, 12, lat);
    bus.vid_req = 1'b0;
    chk({tag, "_lat"}, 32'(lat), 32'd3);
    chk({tag, "_rd"}, 32'(bus.vid_rdata), 32'(ref_mem[a]));
    tick();
  endtask

  initial begin
    int         lat, n, vi, clat, cstart;
    bit         cpend, cdone;
    logic [7:0] d, cw;
    logic [11:0] a;

    reset = 1'b1;
    fill  = 1'b1;
    bus.loading   = 1'b0;
    bus.ld_addr   = '0;
    bus.ld_data   = '0;
    bus.ld_we_n   = 1'b1;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.vid_req   = 1'b0;
    bus.vid_addr  = '0;
    for (int i = 0; i < 4096; i++) ref_mem[i] = init_byte(12'(i));
    repeat (3) tick();
    fill = 1'b0;
    tick();

    chk("rst_cpu_ack",   32'(bus.cpu_ack),   0);
    chk("rst_vid_ack",   32'(bus.vid_ack),   0);
    chk("rst_cpu_rdata", 32'(bus.cpu_rdata), 0);
    chk("rst_vid_rdata", 32'(bus.vid_rdata), 0);
    chk("rst_mem_addr",  32'(bus.mem_addr),  0);
    chk("rst_mem_wdata", 32'(bus.mem_wdata), 0);
    chk("rst_mem_we",    32'(bus.mem_we),    0);
    chk("rst_busy",      32'(bus.busy),      0);
    reset = 1'b0;
    tick();

    // 1: CPU write then read-back
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b1;
    bus.cpu_addr  = 12'h200;
    bus.cpu_wdata = 8'hA5;
    tick();
    chk("wr_acc_we",    32'(bus.mem_we),    1);
    chk("wr_acc_addr",  32'(bus.mem_addr),  32'h200);
    chk("wr_acc_wdata", 32'(bus.mem_wdata), 32'hA5);
    chk("wr_acc_ack",   32'(bus.cpu_ack),   0);
    chk("wr_acc_busy",  32'(bus.busy),      1);
    bus.cpu_addr  = 12'h111;
    bus.cpu_wdata = 8'h00;
    tick();
    chk("wr_done_ack", 32'(bus.cpu_ack), 1);
    chk("wr_done_we",  32'(bus.mem_we),  0);
    bus.cpu_req = 1'b0;
    ref_mem[12'h200] = 8'hA5;
    tick();
    chk("wr_idle_ack", 32'(bus.cpu_ack), 0);
    cpu_op(1'b0, 12'h200, 8'h00, "rd200");
    chk("rd200_cap", 32'(bus.cpu_rdata), 32'hA5);

    // 2: simultaneous requests alternate, CPU first after reset
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 12'h300;
    bus.vid_req  = 1'b1;
    bus.vid_addr = 12'h400;
    n = 0;
    for (int k = 0; k < 40 && n < 4; k++) begin
      tick();
      if (bus.cpu_ack || bus.vid_ack) begin
        chk($sformatf("rr_order%0d", n), 32'(bus.vid_ack),
            32'(n % 2));
        if (bus.vid_ack)
          chk($sformatf("rr_data%0d", n), 32'(bus.vid_rdata),
              32'(ref_mem[12'h400]));
        else
          chk($sformatf("rr_data%0d", n), 32'(bus.cpu_rdata),
              32'(ref_mem[12'h300]));
        n++;
      end
    end
    bus.cpu_req = 1'b0;
    bus.vid_req = 1'b0;
    chk("rr_count", 32'(n), 4);
    tick();

    // 3: loader pass-through with a pending video request
    bus.loading  = 1'b1;
    bus.ld_we_n  = 1'b1;
    bus.vid_req  = 1'b1;
    bus.vid_addr = 12'h201;
    repeat (4) tick();
    for (int i = 0; i < 4; i++) begin
      d = 8'($urandom);
      bus.ld_addr = 12'h200 + 12'(i);
      bus.ld_data = d;
      bus.ld_we_n = 1'b0;
      #1;
      chk($sformatf("ld%0d_addr", i), 32'(bus.mem_addr),
          32'h200 + 32'(i));
      chk($sformatf("ld%0d_data", i), 32'(bus.mem_wdata), 32'(d));
      chk($sformatf("ld%0d_we", i), 32'(bus.mem_we), 1);
      chk($sformatf("ld%0d_vack", i), 32'(bus.vid_ack), 0);
      ref_mem[12'h200 + 12'(i)] = d;
      tick();
    end
    bus.ld_we_n = 1'b1;
    bus.loading = 1'b0;
    wait_ack(1'b1, 12, lat);
    bus.vid_req = 1'b0;
    chk("ld_vid_lat", 32'(lat), 4);
    chk("ld_vid_rd", 32'(bus.vid_rdata), 32'(ref_mem[12'h201]));
    tick();
    for (int i = 0; i < 4; i++)
      cpu_op(1'b0, 12'h200 + 12'(i), 8'h00, $sformatf("ldrb%0d", i));

    // 4: loading rises during ACC of a CPU read
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 12'h202;
    tick();
    bus.loading = 1'b1;
    bus.ld_we_n = 1'b1;
    bus.ld_addr = 12'h5AB;
    tick();
    chk("ldmid_rd_ack", 32'(bus.cpu_ack), 0);
    tick();
    chk("ldmid_done_ack", 32'(bus.cpu_ack), 1);
    chk("ldmid_done_rd", 32'(bus.cpu_rdata), 32'(ref_mem[12'h202]));
    chk("ldmid_done_addr", 32'(bus.mem_addr), 32'h202);
    bus.cpu_req = 1'b0;
    tick();
    chk("ldmid_load_addr", 32'(bus.mem_addr), 32'h5AB);
    chk("ldmid_load_busy", 32'(bus.busy), 1);
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 12'h203;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("ldmid_hold%0d", i), 32'(bus.cpu_ack), 0);
    end
    bus.loading = 1'b0;
    wait_ack(1'b0, 12, lat);
    bus.cpu_req = 1'b0;
    chk("ldmid_pend_lat", 32'(lat), 4);
    chk("ldmid_pend_rd", 32'(bus.cpu_rdata), 32'(ref_mem[12'h203]));
    tick();

    // 5: reset during ACC of a CPU write
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b1;
    bus.cpu_addr  = 12'h350;
    bus.cpu_wdata = ~ref_mem[12'h350];
    tick();
    chk("rstw_acc_we", 32'(bus.mem_we), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("rstw_we", 32'(bus.mem_we), 0);
    chk("rstw_busy", 32'(bus.busy), 0);
    bus.cpu_req = 1'b0;
    tick();
    chk("rstw_ack", 32'(bus.cpu_ack), 0);
    reset = 1'b0;
    tick();
    cpu_op(1'b0, 12'h350, 8'h00, "rstw_keep");

    // 6: video stream with one CPU write injected
    cw     = 8'($urandom);
    cstart = 20 + int'($urandom_range(0, 7));
    vi     = 0;
    clat   = 0;
    cpend  = 1'b0;
    cdone  = 1'b0;
    bus.vid_req  = 1'b1;
    bus.vid_addr = 12'h600;
    for (int c = 0; c < 400 && (vi < 64 || !cdone); c++) begin
      if (c == cstart) begin
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = 12'h7F0;
        bus.cpu_wdata = cw;
        cpend = 1'b1;
      end
      tick();
      if (cpend) clat++;
      if (bus.vid_ack) begin
        chk($sformatf("stream%0d", vi), 32'(bus.vid_rdata),
            32'(ref_mem[12'h600 + 12'(vi)]));
        vi++;
        if (vi == 64) bus.vid_req = 1'b0;
        else bus.vid_addr = 12'h600 + 12'(vi);
      end
      if (bus.cpu_ack) begin
        chk("stream_cpu_lat_le7", 32'(clat <= 7), 1);
        bus.cpu_req = 1'b0;
        cpend = 1'b0;
        cdone = 1'b1;
        ref_mem[12'h7F0] = cw;
      end
    end
    bus.vid_req = 1'b0;
    bus.cpu_req = 1'b0;
    chk("stream_count", 32'(vi), 64);
    chk("stream_cpu_done", 32'(cdone), 1);
    tick();
    cpu_op(1'b0, 12'h7F0, 8'h00, "stream_wr_chk");

    // randomized single accesses against the shadow memory
    for (int r = 0; r < 24; r++) begin
      a = 12'($urandom);
      d = 8'($urandom);
      n = int'($urandom_range(0, 2));
      if (n == 0) cpu_op(1'b1, a, d, $sformatf("rnd%0d_w", r));
      else if (n == 1) cpu_op(1'b0, a, d, $sformatf("rnd%0d_r", r));
      else vid_op(a, $sformatf("rnd%0d_v", r));
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
